// File: rtl/spi_reg_write_sequencer_pkg.sv
// Shared definitions for the SPI register write sequencer.
//   seq_state_t    : sequencer FSM states (IDLE, ADDR, DATA, DISCARD)
//   register map   : 4 PWM channels x 6 bytes, bases 0/6/12/18, 24 registers
//   next_reg_addr  : address auto-increment with optional wrap at the top
package spi_reg_write_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } seq_state_t;

  localparam int BYTES_PER_CHANNEL = 6;
  localparam int NUM_CHANNELS      = 4;
  localparam int CH0_BASE          = 0;
  localparam int CH1_BASE          = 6;
  localparam int CH2_BASE          = 12;
  localparam int CH3_BASE          = 18;
  localparam int DEFAULT_NUM_REGS  = NUM_CHANNELS * BYTES_PER_CHANNEL;

  // Next write address after a data byte. At the top of the map the
  // address either wraps to 0 or holds (the FSM then discards the rest).
  function automatic logic [7:0] next_reg_addr(input logic [7:0] addr,
                                               input logic [7:0] last_addr,
                                               input logic       wrap);
    if (addr == last_addr) begin
      return wrap ? 8'd0 : addr;
    end
    return addr + 8'd1;
  endfunction

endpackage

// File: rtl/spi_reg_write_sequencer_toggle_synchronizer.sv
// Toggle synchronizer: two flops bring an asynchronous level into the CLK
// domain, a third flop detects changes of the synchronized level.
//   CLK      in  system clock
//   RST      in  asynchronous active-high reset (flops load ResetLevel)
//   AsyncIn  in  asynchronous level / toggle input
//   Level    out synchronized level (second flop)
//   Pulse    out one-cycle pulse whenever the synchronized level changes
module spi_reg_write_sequencer_toggle_synchronizer #(
  parameter logic ResetLevel = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic AsyncIn,
  output logic Level,
  output logic Pulse
);

  // sync_q[0], sync_q[1]: metastability chain; sync_q[2]: previous level.
  logic [2:0] sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= {3{ResetLevel}};
    end else begin
      sync_q <= {sync_q[1:0], AsyncIn};
    end
  end

  assign Level = sync_q[1];
  assign Pulse = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/spi_reg_write_sequencer.sv
// SPI register write sequencer. Turns each SPI frame into register writes:
// the first byte of a frame is the start address, every later byte is
// written to the current address, which then auto-increments.
//   CLK          in   system clock (at least 4x SCLK)
//   RST          in   asynchronous active-high reset
//   _CS          in   host chip select, active low, asynchronous
//   RXToggle     in   toggles once per received SPI byte, asynchronous
//   RXByte       in   received byte, stable until the next byte completes
//   AddressBus   out  register address
//   WriteBus     out  write data
//   _Write       out  active-low write strobe, one CLK cycle per data byte
//   FrameActive  out  high while the FSM is not IDLE
//   ByteCount    out  bytes received in the current frame, saturating at 255
//   AddrError    out  sticky: an address byte was out of range
//   FsmState     out  current FSM state (debug visibility)
//
// Handshake: there is no back-pressure. A byte is accepted on the single
// cycle its synchronized toggle changes (byte_evt); the register bank must
// take WriteBus/AddressBus on the one cycle _Write is low.
module spi_reg_write_sequencer
  import spi_reg_write_sequencer_pkg::*;
#(
  parameter int NumOfRegisters = DEFAULT_NUM_REGS,
  parameter int AutoWrap       = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       _CS,
  input  logic       RXToggle,
  input  logic [7:0] RXByte,
  output logic [7:0] AddressBus,
  output logic [7:0] WriteBus,
  output logic       _Write,
  output logic       FrameActive,
  output logic [7:0] ByteCount,
  output logic       AddrError,
  output logic [1:0] FsmState
);

  localparam logic [7:0] LAST_ADDR = 8'(NumOfRegisters - 1);
  localparam logic       WRAP      = (AutoWrap != 0);

  logic cs_n_sync;
  logic cs_edge_unused;
  logic rx_level_unused;
  logic byte_evt;

  spi_reg_write_sequencer_toggle_synchronizer #(.ResetLevel(1'b1)) u_cs_sync (
    .CLK     (CLK),
    .RST     (RST),
    .AsyncIn (_CS),
    .Level   (cs_n_sync),
    .Pulse   (cs_edge_unused)
  );

  spi_reg_write_sequencer_toggle_synchronizer #(.ResetLevel(1'b0)) u_rx_sync (
    .CLK     (CLK),
    .RST     (RST),
    .AsyncIn (RXToggle),
    .Level   (rx_level_unused),
    .Pulse   (byte_evt)
  );

  seq_state_t state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_n_q, write_n_d;
  logic [7:0] count_q, count_d;
  logic       err_q, err_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      write_n_q <= 1'b1;
      count_q   <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_n_q <= write_n_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_n_d = 1'b1;
    count_d   = count_q;
    err_d     = err_q;

    // The cycle after a strobe advances the address. This runs in every
    // state so a strobe still pending when _CS rises completes normally.
    if (!write_n_q) begin
      addr_d = next_reg_addr(addr_q, LAST_ADDR, WRAP);
    end

    if (byte_evt && (state_q != ST_IDLE) && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!cs_n_sync) begin
          state_d = ST_ADDR;
          count_d = 8'd0;
          err_d   = 1'b0;
        end
      end
      ST_ADDR: begin
        if (byte_evt) begin
          if (RXByte <= LAST_ADDR) begin
            addr_d  = RXByte;
            state_d = ST_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DATA: begin
        if (byte_evt) begin
          wdata_d   = RXByte;
          write_n_d = 1'b0;
          if (!WRAP && (addr_q == LAST_ADDR)) begin
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // End of frame wins over the next state, but the byte seen in this
    // same cycle has already been processed above.
    if ((state_q != ST_IDLE) && cs_n_sync) begin
      state_d = ST_IDLE;
    end
  end

  assign AddressBus  = addr_q;
  assign WriteBus    = wdata_q;
  assign _Write      = write_n_q;
  assign FrameActive = (state_q != ST_IDLE);
  assign ByteCount   = count_q;
  assign AddrError   = err_q;
  assign FsmState    = state_q;

endmodule

// File: tb/tb_spi_reg_write_sequencer.sv
module tb_spi_reg_write_sequencer;
  import spi_reg_write_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       rx_toggle = 1'b0;
  logic [7:0] rx_byte = 8'd0;

  always #5 clk = ~clk;

  logic [7:0] addr_a, wdata_a, count_a;
  logic       write_n_a, frame_a, err_a;
  logic [1:0] state_a;
  logic [7:0] addr_b, wdata_b, count_b;
  logic       write_n_b, frame_b, err_b;
  logic [1:0] state_b;

  spi_reg_write_sequencer #(.NumOfRegisters(24), .AutoWrap(1)) dut_wrap (
    .CLK(clk), .RST(rst), ._CS(cs_n), .RXToggle(rx_toggle), .RXByte(rx_byte),
    .AddressBus(addr_a), .WriteBus(wdata_a), ._Write(write_n_a),
    .FrameActive(frame_a), .ByteCount(count_a), .AddrError(err_a),
    .FsmState(state_a)
  );

  spi_reg_write_sequencer #(.NumOfRegisters(24), .AutoWrap(0)) dut_nowrap (
    .CLK(clk), .RST(rst), ._CS(cs_n), .RXToggle(rx_toggle), .RXByte(rx_byte),
    .AddressBus(addr_b), .WriteBus(wdata_b), ._Write(write_n_b),
    .FrameActive(frame_b), .ByteCount(count_b), .AddrError(err_b),
    .FsmState(state_b)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_a[$];
  logic [15:0] obs_b[$];
  int long_a = 0;
  int long_b = 0;
  logic prev_low_a = 1'b0;
  logic prev_low_b = 1'b0;

  // Strobe monitor: records {address, data} of every low _Write cycle and
  // counts strobes that stay low longer than one cycle.
  always @(negedge clk) begin
    if (!write_n_a) begin
      obs_a.push_back({addr_a, wdata_a});
      if (prev_low_a) long_a++;
    end
    if (!write_n_b) begin
      obs_b.push_back({addr_b, wdata_b});
      if (prev_low_b) long_b++;
    end
    prev_low_a = !write_n_a;
    prev_low_b = !write_n_b;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte   = b;
    rx_toggle = ~rx_toggle;
    wait_cycles(40);
  endtask

  task automatic frame_start;
    cs_n = 1'b0;
    wait_cycles(6);
  endtask

  task automatic frame_end;
    cs_n = 1'b1;
    wait_cycles(6);
  endtask

  task automatic clear_sb;
    exp_q.delete();
    obs_a.delete();
    obs_b.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    wait_cycles(4);
    checks++; if (addr_a !== 8'd0)  begin errors++; $display("FAIL reset_addr: got %h expected 00", addr_a); end
    checks++; if (wdata_a !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 00", wdata_a); end
    checks++; if (write_n_a !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b expected 1", write_n_a); end
    checks++; if (frame_a !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame_a); end
    checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL reset_count: got %h expected 00", count_a); end
    checks++; if (err_a !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b expected 0", err_a); end
    checks++; if (state_a !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_a); end
    rst = 1'b0;
    wait_cycles(4);
  endtask

  task automatic test_single_write;
    int  edges;
    bit  seen;
    clear_sb();
    exp_q.push_back({8'h06, 8'hA5});
    frame_start();
    send_byte(8'(CH1_BASE));
    rx_byte   = 8'hA5;
    rx_toggle = ~rx_toggle;
    edges = 0;
    seen  = 1'b0;
    while (edges < 8 && !seen) begin
      @(posedge clk);
      edges++;
      #1;
      if (!write_n_a) seen = 1'b1;
    end
    checks++; if (edges !== 3) begin errors++; $display("FAIL single_latency: got %0d edges expected 3", edges); end
    wait_cycles(36);
    checks++; if (frame_a !== 1'b1) begin errors++; $display("FAIL single_frame_active: got %b expected 1", frame_a); end
    frame_end();
    checks++; if (obs_a.size() !== exp_q.size()) begin errors++; $display("FAIL single_nwrites: got %0d expected %0d", obs_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL single_write%0d: got %h expected %h", i, obs_a[i], exp_q[i]); end
    end
    checks++; if (addr_a !== 8'h07) begin errors++; $display("FAIL single_addr_after: got %h expected 07", addr_a); end
    checks++; if (count_a !== 8'd2) begin errors++; $display("FAIL single_count: got %0d expected 2", count_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err_a); end
    checks++; if (frame_a !== 1'b0) begin errors++; $display("FAIL single_frame_end: got %b expected 0", frame_a); end
  endtask

  task automatic test_burst;
    clear_sb();
    frame_start();
    send_byte(8'(CH0_BASE));
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({8'(i), 8'(8'h10 + i)});
      send_byte(8'(8'h10 + i));
    end
    checks++; if (count_a !== 8'd7) begin errors++; $display("FAIL burst_count: got %0d expected 7", count_a); end
    frame_end();
    checks++; if (obs_a.size() !== exp_q.size()) begin errors++; $display("FAIL burst_nwrites: got %0d expected %0d", obs_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL burst_write%0d: got %h expected %h", i, obs_a[i], exp_q[i]); end
    end
    checks++; if (addr_a !== 8'h06) begin errors++; $display("FAIL burst_addr_after: got %h expected 06", addr_a); end
    checks++; if (long_a !== 0) begin errors++; $display("FAIL burst_strobe_width: got %0d long strobes expected 0", long_a); end
  endtask

  task automatic test_wrap;
    clear_sb();
    frame_start();
    send_byte(8'(CH3_BASE + 5));
    send_byte(8'h11);
    send_byte(8'h22);
    checks++; if (state_b !== ST_DISCARD) begin errors++; $display("FAIL nowrap_state: got %0d expected 3", state_b); end
    frame_end();
    exp_q.push_back({8'd23, 8'h11});
    exp_q.push_back({8'd0,  8'h22});
    checks++; if (obs_a.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_nwrites: got %0d expected %0d", obs_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_write%0d: got %h expected %h", i, obs_a[i], exp_q[i]); end
    end
    checks++; if (addr_a !== 8'h01) begin errors++; $display("FAIL wrap_addr_after: got %h expected 01", addr_a); end
    checks++; if (obs_b.size() !== 1) begin errors++; $display("FAIL nowrap_nwrites: got %0d expected 1", obs_b.size()); end
    if (obs_b.size() > 0) begin
      checks++; if (obs_b[0] !== 16'h1711) begin errors++; $display("FAIL nowrap_write0: got %h expected 1711", obs_b[0]); end
    end
    checks++; if (addr_b !== 8'd23) begin errors++; $display("FAIL nowrap_addr_after: got %h expected 17", addr_b); end
    checks++; if (count_b !== 8'd3) begin errors++; $display("FAIL nowrap_count: got %0d expected 3", count_b); end
    checks++; if (long_b !== 0) begin errors++; $display("FAIL nowrap_strobe_width: got %0d long strobes expected 0", long_b); end
  endtask

  task automatic test_bad_address;
    clear_sb();
    frame_start();
    send_byte(8'h30);
    send_byte(8'h55);
    checks++; if (state_a !== ST_DISCARD) begin errors++; $display("FAIL bad_state: got %0d expected 3", state_a); end
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL bad_err: got %b expected 1", err_a); end
    checks++; if (count_a !== 8'd2) begin errors++; $display("FAIL bad_count: got %0d expected 2", count_a); end
    checks++; if (obs_a.size() !== 0) begin errors++; $display("FAIL bad_nwrites: got %0d expected 0", obs_a.size()); end
    checks++; if (addr_a !== 8'h01) begin errors++; $display("FAIL bad_addr_hold: got %h expected 01", addr_a); end
    frame_end();
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b expected 1", err_a); end
    frame_start();
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL bad_err_clear: got %b expected 0", err_a); end
    checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL bad_count_clear: got %0d expected 0", count_a); end
    frame_end();
  endtask

  task automatic test_coincident_end;
    clear_sb();
    exp_q.push_back({8'd12, 8'h77});
    exp_q.push_back({8'd13, 8'h88});
    frame_start();
    send_byte(8'(CH2_BASE));
    send_byte(8'h77);
    rx_byte   = 8'h88;
    rx_toggle = ~rx_toggle;
    cs_n      = 1'b1;
    wait_cycles(40);
    checks++; if (obs_a.size() !== exp_q.size()) begin errors++; $display("FAIL coinc_nwrites: got %0d expected %0d", obs_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL coinc_write%0d: got %h expected %h", i, obs_a[i], exp_q[i]); end
    end
    checks++; if (addr_a !== 8'd14) begin errors++; $display("FAIL coinc_addr_after: got %h expected 0e", addr_a); end
    checks++; if (frame_a !== 1'b0) begin errors++; $display("FAIL coinc_frame: got %b expected 0", frame_a); end
    checks++; if (count_a !== 8'd3) begin errors++; $display("FAIL coinc_count: got %0d expected 3", count_a); end
  endtask

  task automatic test_idle_byte;
    clear_sb();
    send_byte(8'h99);
    checks++; if (obs_a.size() !== 0) begin errors++; $display("FAIL idle_nwrites: got %0d expected 0", obs_a.size()); end
    checks++; if (count_a !== 8'd3) begin errors++; $display("FAIL idle_count: got %0d expected 3", count_a); end
    checks++; if (addr_a !== 8'd14) begin errors++; $display("FAIL idle_addr: got %h expected 0e", addr_a); end
  endtask

  task automatic test_reset_mid_frame;
    clear_sb();
    frame_start();
    send_byte(8'(CH2_BASE));
    rx_byte   = 8'h5A;
    rx_toggle = ~rx_toggle;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (addr_a !== 8'd0) begin errors++; $display("FAIL rstmid_addr: got %h expected 00", addr_a); end
    checks++; if (write_n_a !== 1'b1) begin errors++; $display("FAIL rstmid_write_n: got %b expected 1", write_n_a); end
    checks++; if (frame_a !== 1'b0) begin errors++; $display("FAIL rstmid_frame: got %b expected 0", frame_a); end
    checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count_a); end
    checks++; if (state_a !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", state_a); end
    cs_n = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(10);
    checks++; if (obs_a.size() !== 0) begin errors++; $display("FAIL rstmid_nostrobe: got %0d writes expected 0", obs_a.size()); end
    exp_q.push_back({8'd18, 8'h3C});
    frame_start();
    send_byte(8'(CH3_BASE));
    send_byte(8'h3C);
    frame_end();
    checks++; if (obs_a.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_nwrites: got %0d expected %0d", obs_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_write%0d: got %h expected %h", i, obs_a[i], exp_q[i]); end
    end
    checks++; if (addr_a !== 8'd19) begin errors++; $display("FAIL rstmid_addr_after: got %h expected 13", addr_a); end
    checks++; if (count_a !== 8'd2) begin errors++; $display("FAIL rstmid_count_after: got %0d expected 2", count_a); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_wrap();
    test_bad_address();
    test_coincident_end();
    test_idle_byte();
    test_reset_mid_frame();
    checks++; if (long_a !== 0) begin errors++; $display("FAIL final_strobe_width: got %0d long strobes expected 0", long_a); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
